// File: rtl/bit_usage_pkg.sv
// Shared types for the runtime bit-usage monitor.
// Scan FSM states, report kind encodings and the per-bit classifier.
package bit_usage_pkg;

  typedef enum logic [1:0] {
    MONITOR,
    SCAN,
    EMIT,
    DONE
  } state_e;

  localparam logic [1:0] KIND_UNDRIVEN = 2'b01;
  localparam logic [1:0] KIND_UNUSED   = 2'b10;
  localparam logic [1:0] KIND_BOTH     = 2'b11;

  function automatic logic [1:0] bit_kind(
    input logic drv,
    input logic used
  );
    logic [1:0] k;
    k = 2'b00;
    if (!drv)  k = k | KIND_UNDRIVEN;
    if (!used) k = k | KIND_UNUSED;
    return k;
  endfunction

endpackage

// File: rtl/bit_usage_monitor.sv
// Sticky driven/used masks over a packed vector, with an on-demand
// scan that streams one report per undriven and/or unused bit.
module bit_usage_monitor
  import bit_usage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] rd_mask,
  input  logic             clr,
  input  logic             report_req,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [IDX_W-1:0] rpt_idx,
  output logic [1:0]       rpt_kind,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   rpt_count
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [1:0]       kind;
  } rpt_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] drv_q, drv_d;
  logic [WIDTH-1:0] used_q, used_d;
  rpt_t             rpt_q, rpt_d;
  logic             valid_q, valid_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [1:0]       kind;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MONITOR;
      idx_q   <= '0;
      drv_q   <= '0;
      used_q  <= '0;
      rpt_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drv_q   <= drv_d;
      used_q  <= used_d;
      rpt_q   <= rpt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drv_d   = drv_q;
    used_d  = used_q;
    rpt_d   = rpt_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    kind    = bit_kind(drv_q[idx_q], used_q[idx_q]);
    unique case (state_q)
      MONITOR: begin
        // clr dominates any same-cycle observation
        if (clr) begin
          drv_d  = '0;
          used_d = '0;
        end else begin
          if (wr_en) drv_d  = drv_q | wr_mask;
          if (rd_en) used_d = used_q | rd_mask;
        end
        if (report_req) begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (kind != 2'b00) begin
          rpt_d.idx  = idx_q;
          rpt_d.kind = kind;
          valid_d    = 1'b1;
          state_d    = EMIT;
        end else if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      EMIT: begin
        if (valid_q && rpt_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + (IDX_W+1)'(1);
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        state_d = MONITOR;
      end
      default: begin
        state_d = MONITOR;
      end
    endcase
  end

  assign rpt_valid = valid_q;
  assign rpt_idx   = rpt_q.idx;
  assign rpt_kind  = rpt_q.kind;
  assign busy      = (state_q != MONITOR);
  assign done      = (state_q == DONE);
  assign rpt_count = cnt_q;

endmodule

// File: tb/tb_bit_usage_monitor.sv
// Scoreboard bench for bit_usage_monitor: directed scans with
// hand-listed expected report streams checked by a separate monitor.
module tb_bit_usage_monitor;
  import bit_usage_pkg::*;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_mask;
  logic             rd_en;
  logic [WIDTH-1:0] rd_mask;
  logic             clr;
  logic             report_req;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [IDX_W-1:0] rpt_idx;
  logic [1:0]       rpt_kind;
  logic             busy;
  logic             done;
  logic [IDX_W:0]   rpt_count;

  int checks;
  int errors;
  int exp_count;
  int done_cnt;
  int lat;
  int exp_q[$];

  bit_usage_monitor #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_mask   (wr_mask),
    .rd_en     (rd_en),
    .rd_mask   (rd_mask),
    .clr       (clr),
    .report_req(report_req),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_idx   (rpt_idx),
    .rpt_kind  (rpt_kind),
    .busy      (busy),
    .done      (done),
    .rpt_count (rpt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // entry encoded as idx*4 + kind
  task automatic push(input int idx, input int kind);
    exp_q.push_back(idx * 4 + kind);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rpt_valid && rpt_kind == 2'b00)
        check("kind_nonzero", 0, 1);
      if (rpt_valid && rpt_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_entry", int'(rpt_idx) * 4 + int'(rpt_kind), -1);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("entry_idx", int'(rpt_idx), e / 4);
          check("entry_kind", int'(rpt_kind), e % 4);
        end
      end
      if (done) begin
        done_cnt++;
        check("rpt_count", int'(rpt_count), exp_count);
        check("missing_entries", exp_q.size(), 0);
      end
    end
  end

  task automatic start_scan();
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    clr        = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
    tick();
    check("done_single", int'(done), 0);
    check("busy_idle", int'(busy), 0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!rpt_valid && n < 100) begin
      tick();
      n++;
    end
    if (!rpt_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic write(input logic [WIDTH-1:0] m);
    wr_en   = 1'b1;
    wr_mask = m;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks     = 0;
    errors     = 0;
    done_cnt   = 0;
    exp_count  = 0;
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_mask    = '0;
    rd_en      = 1'b0;
    rd_mask    = '0;
    clr        = 1'b0;
    report_req = 1'b0;
    rpt_ready  = 1'b1;
    #3;
    check("rst_valid", int'(rpt_valid), 0);
    check("rst_idx", int'(rpt_idx), 0);
    check("rst_kind", int'(rpt_kind), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(rpt_count), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // nothing observed: every bit is undriven and unused
    for (int i = 0; i < 16; i++) push(i, 3);
    exp_count = 16;
    start_scan();
    check("busy_scan", int'(busy), 1);
    wait_done(lat);

    // read issued together with report_req is still seen by the scan
    write(16'h9400);
    for (int i = 0; i < 10; i++) push(i, 3);
    push(11, 1);
    push(13, 1);
    push(14, 1);
    exp_count = 13;
    rd_en   = 1'b1;
    rd_mask = 16'hFC00;
    start_scan();
    wait_done(lat);

    // fully covered: no entries, done at N+WIDTH+1
    write(16'hFFFF);
    rd_en   = 1'b1;
    rd_mask = 16'hFFFF;
    tick();
    rd_en   = 1'b0;
    exp_count = 0;
    start_scan();
    wait_done(lat);
    check("latency", lat, WIDTH);

    // backpressure: only bit 3 flagged, held 5 cycles
    clr = 1'b1;
    tick();
    clr = 1'b0;
    write(16'hFFF7);
    rd_en   = 1'b1;
    rd_mask = 16'hFFF7;
    tick();
    rd_en   = 1'b0;
    rpt_ready = 1'b0;
    push(3, int'(KIND_BOTH));
    exp_count = 1;
    start_scan();
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", int'(rpt_valid), 1);
      check("hold_idx", int'(rpt_idx), 3);
      check("hold_kind", int'(rpt_kind), 3);
      check("hold_busy", int'(busy), 1);
      tick();
    end
    rpt_ready = 1'b1;
    wait_done(lat);

    // writes during EMIT are ignored
    clr = 1'b1;
    tick();
    clr = 1'b0;
    write(16'hFFFE);
    rd_en   = 1'b1;
    rd_mask = 16'hFFFF;
    tick();
    rd_en   = 1'b0;
    rpt_ready = 1'b0;
    push(0, 1);
    exp_count = 1;
    start_scan();
    wait_valid();
    write(16'h0001);
    rpt_ready = 1'b1;
    wait_done(lat);
    push(0, 1);
    exp_count = 1;
    start_scan();
    wait_done(lat);

    // reset mid-EMIT drops the entry
    rpt_ready = 1'b0;
    start_scan();
    wait_valid();
    rst = 1'b1;
    #1;
    check("rst_emit_valid", int'(rpt_valid), 0);
    check("rst_emit_busy", int'(busy), 0);
    check("rst_emit_count", int'(rpt_count), 0);
    check("rst_emit_done", int'(done), 0);
    tick();
    rst = 1'b0;
    rpt_ready = 1'b1;
    tick();

    // clr wins over same-cycle writes and the scan sees cleared masks
    write(16'h00FF);
    rd_en   = 1'b1;
    rd_mask = 16'h0F0F;
    tick();
    rd_en   = 1'b0;
    for (int i = 0; i < 16; i++) push(i, 3);
    exp_count = 16;
    clr     = 1'b1;
    wr_en   = 1'b1;
    wr_mask = 16'hFFFF;
    rd_en   = 1'b1;
    rd_mask = 16'hFFFF;
    start_scan();
    wait_done(lat);

    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);
    check("done_pulses", done_cnt, 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
